// File: rtl/axis_rx_framer_if.sv
// axis_rx_framer_if: AXI-stream bundle shared by the raw DMA side and the payload side.
interface axis_rx_framer_if #(
  parameter int DW = 32,
  parameter int TW = 2
);
  logic [DW-1:0] tdata;
  logic [TW-1:0] tid;
  logic          tvalid;
  logic          tlast;
  logic          tready;
  modport master (output tdata, tid, tvalid, tlast, input tready);
  modport slave (input tdata, tid, tvalid, tlast, output tready);
endinterface

// File: rtl/axis_rx_framer.sv
// axis_rx_framer: strips a DMA header beat, forwards the payload with a latched TID and
// length-checked TLAST through a 2-entry registered skid buffer, and flags malformed packets.
module axis_rx_framer #(
  parameter int TDATA_WDT = 32,
  parameter int TID_WDT = 2,
  parameter int LEN_WDT = 16,
  parameter logic [TID_WDT-1:0] W_ID = 0,
  parameter logic [TID_WDT-1:0] B_ID = 1,
  parameter logic [TID_WDT-1:0] I_ID = 2
) (
  input  logic clk,
  input  logic rst_n,
  axis_rx_framer_if.slave s_axis,
  axis_rx_framer_if.master m_axis,
  input  logic rx_en_i,
  input  logic err_clr_i,
  output logic hdr_err_o,
  output logic id_err_o,
  output logic len_err_o,
  output logic pkt_done_o,
  output logic [15:0] pkt_cnt_o
);
  typedef enum logic [1:0] {F_HDR, F_PAY, F_DROP} state_t;
  typedef struct packed {
    logic [TDATA_WDT-1:0] data;
    logic [TID_WDT-1:0]   tid;
    logic                 last;
    logic                 good;
  } ent_t;
  state_t state_q;
  logic [TID_WDT-1:0] id_q, h_id;
  logic [LEN_WDT-1:0] len_q, cnt_q, h_len;
  ent_t e_q [2];
  ent_t ent_d;
  logic [1:0] v_q, v_d;
  logic acc, push, pop, at_end, hdr_ok, hdr_set, id_set, len_set, done_d;
  always_comb begin
    h_id = s_axis.tdata[TID_WDT-1:0];
    h_len = s_axis.tdata[16 +: LEN_WDT];
    hdr_ok = (h_id == W_ID || h_id == B_ID || h_id == I_ID) && h_len != '0;
    at_end = cnt_q == len_q - LEN_WDT'(1);
    s_axis.tready = state_q == F_HDR ? rx_en_i : state_q == F_PAY ? !v_q[1] : 1'b1;
    acc = s_axis.tvalid && s_axis.tready;
    push = acc && state_q == F_PAY;
    pop = v_q[0] && m_axis.tready;
    hdr_set = acc && state_q == F_HDR && s_axis.tlast;
    id_set = acc && state_q == F_HDR && !s_axis.tlast && !hdr_ok;
    len_set = push && (s_axis.tlast != at_end);
    ent_d = '{data: s_axis.tdata, tid: id_q, last: s_axis.tlast || at_end, good: s_axis.tlast && at_end};
    v_d = push && !pop ? {v_q[0], 1'b1} : pop && !push ? {1'b0, v_q[1]} : v_q;
    done_d = pop && e_q[0].last && e_q[0].good;
  end
  assign m_axis.tdata = e_q[0].data;
  assign m_axis.tid = e_q[0].tid;
  assign m_axis.tlast = e_q[0].last;
  assign m_axis.tvalid = v_q[0];
  // Entry 0 always holds the head so M outputs come straight from flops.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      v_q <= '0;
      e_q[0] <= '0;
      e_q[1] <= '0;
    end else begin
      v_q <= v_d;
      if (pop) begin
        e_q[0] <= v_q[1] ? e_q[1] : ent_d;
        e_q[1] <= ent_d;
      end else if (push) begin
        if (v_q[0]) e_q[1] <= ent_d;
        else e_q[0] <= ent_d;
      end
    end
  end
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= F_HDR;
      id_q <= '0;
      len_q <= '0;
      cnt_q <= '0;
      hdr_err_o <= 1'b0;
      id_err_o <= 1'b0;
      len_err_o <= 1'b0;
      pkt_done_o <= 1'b0;
      pkt_cnt_o <= '0;
    end else begin
      hdr_err_o <= (hdr_err_o && !err_clr_i) || hdr_set;
      id_err_o <= (id_err_o && !err_clr_i) || id_set;
      len_err_o <= (len_err_o && !err_clr_i) || len_set;
      pkt_done_o <= done_d;
      pkt_cnt_o <= pkt_cnt_o + 16'(done_d);
      if (acc)
        case (state_q)
          F_HDR:
            if (!s_axis.tlast) begin
              state_q <= hdr_ok ? F_PAY : F_DROP;
              id_q <= h_id;
              len_q <= h_len;
              cnt_q <= '0;
            end
          F_PAY: begin
            cnt_q <= cnt_q + LEN_WDT'(1);
            if (ent_d.last) state_q <= s_axis.tlast ? F_HDR : F_DROP;
          end
          default:
            if (s_axis.tlast) state_q <= F_HDR;
        endcase
    end
  end
endmodule
